// File: rtl/if_prefetch_queue.sv
// DLX instruction-fetch front end: owns the fetch PC, issues word reads, and buffers
// returned words in an in-order prefetch FIFO whose head feeds the ID stage.
module if_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [0:31] imem_rdata,
  input  logic        stall_id,
  input  logic        redirect_id,
  input  logic [31:0] redirect_pc_id,
  output logic        inst_valid_id,
  output logic [0:31] inst_id,
  output logic [31:0] pc_id,
  output logic [31:0] pc_plus_four_id
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW-1:0] pq_rd_q, pq_rd_d;
  logic [AW-1:0] pq_wr_q, pq_wr_d;
  logic [0:31]   inst_mem_q [DEPTH];
  logic [0:31]   inst_mem_d [DEPTH];
  logic [31:0]   ipc_mem_q  [DEPTH];
  logic [31:0]   ipc_mem_d  [DEPTH];
  logic [31:0]   pq_mem_q   [DEPTH];
  logic [31:0]   pq_mem_d   [DEPTH];

  logic [CW:0]   credit_sum_s;
  logic          accept_s;
  logic          rsp_s;
  logic          push_s;
  logic          drop_hit_s;
  logic          pop_s;
  logic [CW-1:0] accept_inc_s;
  logic [CW-1:0] rsp_dec_s;
  logic [CW-1:0] push_inc_s;
  logic [CW-1:0] pop_dec_s;
  logic [CW-1:0] rst_drop_s;
  logic          unused_s;

  assign unused_s     = ^redirect_pc_id[1:0];
  assign credit_sum_s = {1'b0, count_q} + {1'b0, outstanding_q};

  assign imem_req  = !reset && !redirect_id && (credit_sum_s < {1'b0, DEPTH_C});
  assign imem_addr = fetch_pc_q;

  assign inst_valid_id   = (count_q != '0);
  assign inst_id         = inst_valid_id ? inst_mem_q[head_q] : 32'h0;
  assign pc_id           = inst_valid_id ? ipc_mem_q[head_q] : 32'h0;
  assign pc_plus_four_id = pc_id + 32'd4;

  // A response with nothing outstanding is a protocol error and is ignored entirely.
  always_comb begin
    accept_s     = imem_req && imem_ready;
    rsp_s        = imem_rvalid && (outstanding_q != '0);
    drop_hit_s   = rsp_s && (drop_q != '0);
    push_s       = rsp_s && (drop_q == '0) && !redirect_id;
    pop_s        = inst_valid_id && !stall_id && !redirect_id;
    accept_inc_s = {{(CW-1){1'b0}}, accept_s};
    rsp_dec_s    = {{(CW-1){1'b0}}, rsp_s};
    push_inc_s   = {{(CW-1){1'b0}}, push_s};
    pop_dec_s    = {{(CW-1){1'b0}}, pop_s};
    // Responses still in flight when reset hits belong to the old stream.
    if (outstanding_q <= DEPTH_C) begin
      rst_drop_s = outstanding_q - rsp_dec_s;
    end else begin
      rst_drop_s = '0;
    end
  end

  // Next-state for pointers, counters, fetch PC and the storage arrays.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    head_d        = head_q;
    tail_d        = tail_q;
    pq_rd_d       = pq_rd_q;
    pq_wr_d       = pq_wr_q;
    inst_mem_d    = inst_mem_q;
    ipc_mem_d     = ipc_mem_q;
    pq_mem_d      = pq_mem_q;
    if (redirect_id) begin
      // Everything in flight is stale; the PC FIFO restarts with the new stream.
      fetch_pc_d    = {redirect_pc_id[31:2], 2'b00};
      count_d       = '0;
      head_d        = '0;
      tail_d        = '0;
      pq_rd_d       = '0;
      pq_wr_d       = '0;
      outstanding_d = outstanding_q - rsp_dec_s;
      drop_d        = outstanding_q - rsp_dec_s;
    end else begin
      if (accept_s) begin
        fetch_pc_d        = fetch_pc_q + 32'd4;
        pq_mem_d[pq_wr_q] = fetch_pc_q;
        pq_wr_d           = pq_wr_q + PTR_ONE;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (push_s) begin
        inst_mem_d[tail_q] = imem_rdata;
        ipc_mem_d[tail_q]  = pq_mem_q[pq_rd_q];
        tail_d             = tail_q + PTR_ONE;
        pq_rd_d            = pq_rd_q + PTR_ONE;
      end else begin
        tail_d = tail_q;
      end
      if (pop_s) begin
        head_d = head_q + PTR_ONE;
      end else begin
        head_d = head_q;
      end
      if (drop_hit_s) begin
        drop_d = drop_q - {{(CW-1){1'b0}}, 1'b1};
      end else begin
        drop_d = drop_q;
      end
      outstanding_d = outstanding_q + accept_inc_s - rsp_dec_s;
      count_d       = count_q + push_inc_s - pop_dec_s;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= rst_drop_s;
      drop_q        <= rst_drop_s;
      head_q        <= '0;
      tail_q        <= '0;
      pq_rd_q       <= '0;
      pq_wr_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      pq_rd_q       <= pq_rd_d;
      pq_wr_q       <= pq_wr_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters.
  always_ff @(posedge clk) begin
    inst_mem_q <= inst_mem_d;
    ipc_mem_q  <= ipc_mem_d;
    pq_mem_q   <= pq_mem_d;
  end

  if_prefetch_queue_chk #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_chk (
    .clk         (clk),
    .reset       (reset),
    .imem_rvalid (imem_rvalid),
    .count       (count_q),
    .outstanding (outstanding_q)
  );

endmodule

// Protocol and occupancy checks for the prefetch queue.
module if_prefetch_queue_chk #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input logic          clk,
  input logic          reset,
  input logic          imem_rvalid,
  input logic [CW-1:0] count,
  input logic [CW-1:0] outstanding
);

  // Flag responses with nothing outstanding and any credit overrun.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(imem_rvalid && (outstanding == '0)));
      assert (({1'b0, count} + {1'b0, outstanding}) <= (CW+1)'(DEPTH));
    end
  end

endmodule
